fifo_stream_reader: RTL and testbench

- Read-side adapter for the team's synchronous FIFO. The FIFO has a registered `data_out`, valid one cycle after an accepted `r_en` while not empty.
- Issues FIFO reads and absorbs the one-cycle read latency in a 2-entry output buffer.
- Presents the data as a valid/ready stream at full throughput (1 word/cycle) while both sides are ready.
- Sits between the FIFO and any downstream consumer. Also provides a flush and a delivered-word counter.

---
 rtl/fifo_stream_reader.sv | 98 +++++++++
 tb/tb_fifo_stream_reader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side adapter for the synchronous FIFO.
// Issues reads, absorbs the one-cycle registered read latency in a
// 2-entry in-order buffer and presents the words as a valid/ready stream
// at one word per cycle. Also provides flush and a delivered-word counter.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_r_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [COUNT_W-1:0]    rd_count
);

  // buf0 is always the head (oldest word); buf1 only holds data when buf_cnt=2
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [COUNT_W-1:0]    rd_count_q, rd_count_d;

  logic       pop;
  logic       capture;
  logic [1:0] occ;

  assign m_valid  = (buf_cnt_q != 2'd0);
  assign m_data   = buf0_q;
  assign rd_count = rd_count_q;

  // Handshake, capture and read-issue decisions
  always_comb begin
    pop     = m_valid & m_ready & ~flush;
    capture = rd_pending_q & ~flush;
    // buffered words plus the one in flight; never exceeds 2
    occ     = buf_cnt_q + {1'b0, rd_pending_q};
    // a pop frees a slot this edge, so a full pipe can still fetch while draining
    fifo_r_en = rst_n & ~flush & ~fifo_empty & ((occ < 2'd2) | pop);
  end

  // Next-state for the buffer, in-flight flag and delivered counter
  always_comb begin
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    buf_cnt_d    = buf_cnt_q;
    rd_pending_d = fifo_r_en;
    rd_count_d   = rd_count_q + {{(COUNT_W-1){1'b0}}, pop};
    if (flush) begin
      // the word arriving from last cycle's read is simply not captured
      buf_cnt_d = 2'd0;
    end else begin
      case ({pop, capture})
        2'b10: begin
          buf0_d    = buf1_q;
          buf_cnt_d = buf_cnt_q - 2'd1;
        end
        2'b01: begin
          if (buf_cnt_q == 2'd0) buf0_d = fifo_rdata;
          else                   buf1_d = fifo_rdata;
          buf_cnt_d = buf_cnt_q + 2'd1;
        end
        2'b11: begin
          // head leaves and the new word appends; count unchanged
          if (buf_cnt_q == 2'd1) begin
            buf0_d = fifo_rdata;
          end else begin
            buf0_d = buf1_q;
            buf1_d = fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf0_q       <= '0;
      buf1_q       <= '0;
      buf_cnt_q    <= 2'd0;
      rd_pending_q <= 1'b0;
      rd_count_q   <= '0;
    end else begin
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      buf_cnt_q    <= buf_cnt_d;
      rd_pending_q <= rd_pending_d;
      rd_count_q   <= rd_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural registered-output FIFO feeding
// the DUT, a queue of expected words filled as the FIFO is loaded and
// drained as the DUT delivers, and a bench-side delivered-word count.
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_r_en;
  logic          flush;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [CW-1:0] rd_count;

  fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_r_en(fifo_r_en), .flush(flush), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  // behavioural FIFO: registered data_out one cycle after an accepted read
  logic [DW-1:0] mem [64];
  logic [5:0]    rptr = '0;
  logic [5:0]    wptr = '0;
  assign fifo_empty = (rptr == wptr);
  always @(posedge clk) begin
    if (fifo_r_en && !fifo_empty) begin
      fifo_rdata <= mem[rptr];
      rptr       <= rptr + 6'd1;
    end
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [CW-1:0] cnt_m = '0;

  task automatic push(input logic [DW-1:0] d);
    mem[wptr] = d;
    wptr      = wptr + 6'd1;
    exp_q.push_back(d);
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    next_cyc(); next_cyc();
    @(negedge clk);
    checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %0b want 0", m_valid); end
    checks++; if (m_data !== 8'h00)  begin errors++; $display("FAIL reset_data got %h want 00", m_data); end
    checks++; if (rd_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", rd_count); end
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_ren got %0b want 0", fifo_r_en); end
    next_cyc();
  endtask

  task automatic test_basic();
    logic [DW-1:0] e;
    push(8'h11); push(8'h22); push(8'h33);
    m_ready = 1'b1;
    rst_n   = 1'b1;
    cnt_m   = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (fifo_r_en !== 1'b1) begin errors++; $display("FAIL basic_first_ren got %0b want 1", fifo_r_en); end
      end
      checks++;
      if (m_valid !== (c >= 2 && c <= 4)) begin
        errors++; $display("FAIL basic_valid cyc %0d got %0b want %0b", c, m_valid, (c >= 2 && c <= 4));
      end
      if (m_valid && m_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front(); cnt_m++;
        checks++; if (m_data !== e) begin errors++; $display("FAIL basic_data got %h want %h", m_data, e); end
      end
      if (c == 5) begin
        checks++; if (rd_count !== 4'd3) begin errors++; $display("FAIL basic_count got %0d want 3", rd_count); end
        checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL basic_idle_ren got %0b want 0", fifo_r_en); end
      end
      next_cyc();
    end
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    logic [DW-1:0] e;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_r_en) pulses++;
      next_cyc();
    end
    @(negedge clk);
    checks++; if (pulses != 2) begin errors++; $display("FAIL bp_pulses got %0d want 2", pulses); end
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hA0) begin
      errors++; $display("FAIL bp_hold got v=%0b d=%h want v=1 d=a0", m_valid, m_data);
    end
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL bp_full_ren got %0b want 0", fifo_r_en); end
    next_cyc();
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== (c < 5)) begin errors++; $display("FAIL bp_stream_valid cyc %0d got %0b want %0b", c, m_valid, (c < 5)); end
      if (m_valid && m_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front(); cnt_m++;
        checks++; if (m_data !== e) begin errors++; $display("FAIL bp_data got %h want %h", m_data, e); end
      end
      next_cyc();
    end
    @(negedge clk);
    checks++; if (rd_count !== 4'd8) begin errors++; $display("FAIL bp_count got %0d want 8", rd_count); end
    next_cyc();
  endtask

  task automatic test_stall();
    logic          held_v = 1'b0;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] e;
    for (int i = 1; i <= 8; i++) push(8'(i));
    m_ready = 1'b1;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (held_v) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          errors++; $display("FAIL stall_stable got v=%0b d=%h want v=1 d=%h", m_valid, m_data, held);
        end
      end
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); cnt_m++;
        checks++; if (m_data !== e) begin errors++; $display("FAIL stall_data got %h want %h", m_data, e); end
      end
      held_v = m_valid && !m_ready;
      held   = m_data;
      next_cyc();
      m_ready = !m_ready;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_timeout left %0d want 0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    checks++; if (rd_count !== cnt_m) begin errors++; $display("FAIL stall_count got %0d want %0d", rd_count, cnt_m); end
    next_cyc();
  endtask

  task automatic test_flush();
    logic [DW-1:0] e;
    m_ready = 1'b0;
    push(8'h44);
    @(negedge clk);
    checks++; if (fifo_r_en !== 1'b1) begin errors++; $display("FAIL flush_ren44 got %0b want 1", fifo_r_en); end
    next_cyc();
    next_cyc();
    push(8'h55);
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h44) begin
      errors++; $display("FAIL flush_pre got v=%0b d=%h want v=1 d=44", m_valid, m_data);
    end
    checks++; if (fifo_r_en !== 1'b1) begin errors++; $display("FAIL flush_ren55 got %0b want 1", fifo_r_en); end
    next_cyc();
    flush = 1'b1; m_ready = 1'b1;
    push(8'h66);
    @(negedge clk);
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL flush_ren_masked got %0b want 0", fifo_r_en); end
    next_cyc();
    flush = 1'b0;
    void'(exp_q.pop_front()); // 0x44 discarded
    void'(exp_q.pop_front()); // 0x55 discarded
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", m_valid); end
    checks++; if (rd_count !== cnt_m) begin errors++; $display("FAIL flush_count got %0d want %0d", rd_count, cnt_m); end
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      if (c > 0) @(negedge clk);
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); cnt_m++;
        checks++; if (m_data !== e) begin errors++; $display("FAIL flush_data got %h want %h", m_data, e); end
      end
      next_cyc();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flush_timeout left %0d want 0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    checks++; if (rd_count !== cnt_m) begin errors++; $display("FAIL flush_count_after got %0d want %0d", rd_count, cnt_m); end
    next_cyc();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    m_ready = 1'b0;
    push(8'hB0); push(8'hB1); push(8'hB2);
    for (int c = 0; c < 5; c++) next_cyc();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL rstmid_ren got %0b want 0", fifo_r_en); end
    @(posedge clk); #2;
    checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL rstmid_valid got %0b want 0", m_valid); end
    checks++; if (m_data !== 8'h00)  begin errors++; $display("FAIL rstmid_data got %h want 00", m_data); end
    checks++; if (rd_count !== 4'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", rd_count); end
    #1;
    rst_n = 1'b1; m_ready = 1'b1; cnt_m = '0;
    void'(exp_q.pop_front()); // 0xB0 lost in buffer
    void'(exp_q.pop_front()); // 0xB1 lost in buffer
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); cnt_m++;
        checks++; if (m_data !== e) begin errors++; $display("FAIL rstmid_data_after got %h want %h", m_data, e); end
      end
      next_cyc();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_timeout left %0d want 0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    checks++; if (rd_count !== 4'd1) begin errors++; $display("FAIL rstmid_restart_count got %0d want 1", rd_count); end
    next_cyc();
  endtask

  task automatic test_wrap();
    logic [DW-1:0] e;
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1; cnt_m = '0; m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        e = exp_q.pop_front(); cnt_m++;
        checks++; if (m_data !== e) begin errors++; $display("FAIL wrap_data got %h want %h", m_data, e); end
      end
      next_cyc();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout left %0d want 0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    checks++; if (rd_count !== 4'd1) begin errors++; $display("FAIL wrap_count got %0d want 1", rd_count); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle got %0b want 0", m_valid); end
    next_cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
